// File: rtl/regfile_wr_arbiter_if.sv
// Write-request bundle between requesters and the register-file write arbiter.
// Stats ports exist only when REGFILE_ARB_STATS_EN is defined.
interface regfile_wr_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]        i_req_valid;
    logic [N_REQ*ADDR_W-1:0] i_req_addr;
    logic [N_REQ*DATA_W-1:0] i_req_data;
    logic                    i_stall;
    logic [N_REQ-1:0]        o_req_ready;
    logic                    o_we;
    logic [ADDR_W-1:0]       o_waddr;
    logic [DATA_W-1:0]       o_wdata;
    logic [IDW-1:0]          o_grant_id;
`ifdef REGFILE_ARB_STATS_EN
    logic [N_REQ*16-1:0]     o_stat_grants;
    logic [15:0]             o_stat_drops;
`endif

    modport slave (
        input  i_req_valid, i_req_addr, i_req_data, i_stall,
        output o_req_ready, o_we, o_waddr, o_wdata, o_grant_id
`ifdef REGFILE_ARB_STATS_EN
        , output o_stat_grants, o_stat_drops
`endif
    );

    modport master (
        output i_req_valid, i_req_addr, i_req_data, i_stall,
        input  o_req_ready, o_we, o_waddr, o_wdata, o_grant_id
`ifdef REGFILE_ARB_STATS_EN
        , input o_stat_grants, o_stat_drops
`endif
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the single register-file write port; r0 writes dropped.
// Optional grant/drop counters enabled by REGFILE_ARB_STATS_EN.
module regfile_wr_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    regfile_wr_arbiter_if.slave  bus
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDW-1:0]    ptr;
    logic [IDW-1:0]    ptr_nxt;
    logic [IDW-1:0]    gnt_id;
    logic              gnt;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;

    function automatic logic [IDW-1:0] rr_idx(
        input logic [IDW-1:0] base,
        input int             off
    );
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return IDW'(s);
    endfunction

    // First valid requester starting at ptr, wrapping around.
    always_comb begin
        gnt    = 1'b0;
        gnt_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!gnt && bus.i_req_valid[rr_idx(ptr, i)]) begin
                gnt    = 1'b1;
                gnt_id = rr_idx(ptr, i);
            end
        end
        if (bus.i_stall || i_rst) gnt = 1'b0;
    end

    always_comb begin
        gnt_addr = '0;
        gnt_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt_id == IDW'(k)) begin
                gnt_addr = bus.i_req_addr[k*ADDR_W +: ADDR_W];
                gnt_data = bus.i_req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign ptr_nxt = (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;

    assign bus.o_req_ready = gnt ? (N_REQ'(1) << gnt_id) : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr            <= '0;
            bus.o_we       <= 1'b0;
            bus.o_waddr    <= '0;
            bus.o_wdata    <= '0;
            bus.o_grant_id <= '0;
        end else begin
            bus.o_we <= gnt && (gnt_addr != '0);
            if (gnt) begin
                ptr            <= ptr_nxt;
                bus.o_waddr    <= gnt_addr;
                bus.o_wdata    <= gnt_data;
                bus.o_grant_id <= gnt_id;
            end
        end
    end

`ifdef REGFILE_ARB_STATS_EN
    logic [15:0] stat_grants [N_REQ];
    logic [15:0] stat_drops;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < N_REQ; k++) stat_grants[k] <= '0;
            stat_drops <= '0;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (gnt && gnt_id == IDW'(k) &&
                    stat_grants[k] != 16'hFFFF)
                    stat_grants[k] <= stat_grants[k] + 16'd1;
            end
            if (gnt && gnt_addr == '0 && stat_drops != 16'hFFFF)
                stat_drops <= stat_drops + 16'd1;
        end
    end

    for (genvar k = 0; k < N_REQ; k++) begin : g_stat
        assign bus.o_stat_grants[k*16 +: 16] = stat_grants[k];
    end
    assign bus.o_stat_drops = stat_drops;
`endif
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: an independent round-robin model
// pushes expected grants/writes, popped after each clock edge.
module tb_regfile_wr_arbiter;
    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    id;
    } exp_t;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;

    regfile_wr_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus();

    regfile_wr_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    exp_t          sb[$];
    exp_t          e;
    exp_t          got;
    int            checks = 0;
    int            fails  = 0;
    logic [1:0]    mptr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [1:0]    m_id;
    logic [N-1:0]  exp_ready;

    task automatic model_reset();
        mptr   = '0;
        m_addr = '0;
        m_data = '0;
        m_id   = '0;
        sb.delete();
    endtask

    task automatic model_cycle();
        int            g;
        logic          hit;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        hit = 1'b0;
        g   = 0;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (int'(mptr) + i) % N;
            if (!hit && bus.i_req_valid[k]) begin
                hit = 1'b1;
                g   = k;
            end
        end
        if (bus.i_stall || i_rst) hit = 1'b0;
        exp_ready = '0;
        if (i_rst) begin
            model_reset();
            sb.push_back('0);
        end else if (hit) begin
            a = AW'(bus.i_req_addr >> (g * AW));
            d = DW'(bus.i_req_data >> (g * DW));
            exp_ready[g] = 1'b1;
            m_addr = a;
            m_data = d;
            m_id   = 2'(g);
            mptr   = 2'((g + 1) % N);
            sb.push_back({(a != '0), a, d, m_id});
        end else begin
            sb.push_back({1'b0, m_addr, m_data, m_id});
        end
    endtask

    task automatic set_req(input int k, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        bus.i_req_addr[k*AW +: AW] = a;
        bus.i_req_data[k*DW +: DW] = d;
    endtask

    task automatic apply_reset();
        i_rst = 1'b1;
        bus.i_req_valid = '0;
        bus.i_stall = 1'b0;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        for (int k = 0; k < N; k++) set_req(k, AW'(k + 1), 32'hC0DE_0000 + k);
        bus.i_req_valid = '1;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) i_rst = 1'b0;
            @(negedge i_clk);
            model_cycle();
            checks++;
            if (bus.o_req_ready !== exp_ready) begin
                fails++;
                $display("FAIL reset_ready c=%0d got=%b exp=%b",
                         c, bus.o_req_ready, exp_ready);
            end
            if (c == 2) begin
                checks++;
                if (bus.o_req_ready !== 4'b0001) begin
                    fails++;
                    $display("FAIL reset_first_grant got=%b exp=0001",
                             bus.o_req_ready);
                end
            end
            @(posedge i_clk);
            #1;
            e   = sb.pop_front();
            got = {bus.o_we, bus.o_waddr, bus.o_wdata, bus.o_grant_id};
            checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL reset_out c=%0d got=%h exp=%h", c, got, e);
            end
        end
        bus.i_req_valid = '0;
    endtask

    task automatic test_single();
        apply_reset();
        for (int k = 0; k < N; k++) set_req(k, AW'(k + 9), 32'h1111_0000 + k);
        set_req(2, 5'd5, 32'hDEAD_BEEF);
        bus.i_req_valid = 4'b0100;
        for (int c = 0; c < 2; c++) begin
            @(negedge i_clk);
            model_cycle();
            checks++;
            if (bus.o_req_ready !== exp_ready) begin
                fails++;
                $display("FAIL single_ready c=%0d got=%b exp=%b",
                         c, bus.o_req_ready, exp_ready);
            end
            @(posedge i_clk);
            #1;
            bus.i_req_valid = bus.i_req_valid & ~exp_ready;
            e   = sb.pop_front();
            got = {bus.o_we, bus.o_waddr, bus.o_wdata, bus.o_grant_id};
            checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL single_out c=%0d got=%h exp=%h", c, got, e);
            end
            if (c == 0) begin
                checks++;
                if (got !== {1'b1, 5'd5, 32'hDEAD_BEEF, 2'd2}) begin
                    fails++;
                    $display("FAIL single_write got=%h exp=%h", got,
                             {1'b1, 5'd5, 32'hDEAD_BEEF, 2'd2});
                end
            end
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int k = 0; k < N; k++) set_req(k, AW'(k + 1), 32'hA000_0000 + k);
        bus.i_req_valid = '1;
        for (int c = 0; c < 9; c++) begin
            if (c == 8) bus.i_req_valid = '0;
            @(negedge i_clk);
            model_cycle();
            checks++;
            if (bus.o_req_ready !== exp_ready) begin
                fails++;
                $display("FAIL rr_ready c=%0d got=%b exp=%b",
                         c, bus.o_req_ready, exp_ready);
            end
            @(posedge i_clk);
            #1;
            e   = sb.pop_front();
            got = {bus.o_we, bus.o_waddr, bus.o_wdata, bus.o_grant_id};
            checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL rr_out c=%0d got=%h exp=%h", c, got, e);
            end
            if (c < 8) begin
                checks++;
                if (bus.o_we !== 1'b1 || bus.o_grant_id !== 2'(c % N)) begin
                    fails++;
                    $display("FAIL rr_order c=%0d got we=%b id=%0d exp we=1 id=%0d",
                             c, bus.o_we, bus.o_grant_id, c % N);
                end
            end
        end
    endtask

    task automatic test_reg0_drop();
        apply_reset();
        for (int k = 0; k < N; k++) set_req(k, AW'(k + 3), 32'h2222_0000 + k);
        set_req(1, 5'd0, 32'h0000_1234);
        bus.i_req_valid = 4'b0010;
        for (int c = 0; c < 2; c++) begin
            @(negedge i_clk);
            model_cycle();
            checks++;
            if (bus.o_req_ready !== exp_ready) begin
                fails++;
                $display("FAIL drop_ready c=%0d got=%b exp=%b",
                         c, bus.o_req_ready, exp_ready);
            end
            @(posedge i_clk);
            #1;
            bus.i_req_valid = bus.i_req_valid & ~exp_ready;
            e   = sb.pop_front();
            got = {bus.o_we, bus.o_waddr, bus.o_wdata, bus.o_grant_id};
            checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL drop_out c=%0d got=%h exp=%h", c, got, e);
            end
        end
`ifdef REGFILE_ARB_STATS_EN
        checks++;
        if (bus.o_stat_drops !== 16'd1 ||
            bus.o_stat_grants[16 +: 16] !== 16'd1) begin
            fails++;
            $display("FAIL drop_stats got drops=%0d g1=%0d exp 1 1",
                     bus.o_stat_drops, bus.o_stat_grants[16 +: 16]);
        end
`endif
    endtask

    task automatic test_stall();
        logic [1:0] order [2];
        int         n;
        order[0] = 2'd0;
        order[1] = 2'd3;
        n = 0;
        apply_reset();
        for (int k = 0; k < N; k++) set_req(k, AW'(k + 20), 32'h3333_0000 + k);
        bus.i_req_valid = 4'b1001;
        bus.i_stall = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) bus.i_stall = 1'b0;
            @(negedge i_clk);
            model_cycle();
            checks++;
            if (bus.o_req_ready !== exp_ready) begin
                fails++;
                $display("FAIL stall_ready c=%0d got=%b exp=%b",
                         c, bus.o_req_ready, exp_ready);
            end
            @(posedge i_clk);
            #1;
            e   = sb.pop_front();
            got = {bus.o_we, bus.o_waddr, bus.o_wdata, bus.o_grant_id};
            checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL stall_out c=%0d got=%h exp=%h", c, got, e);
            end
            if (exp_ready != '0 && n < 2) begin
                checks++;
                if (bus.o_grant_id !== order[n]) begin
                    fails++;
                    $display("FAIL stall_order n=%0d got=%0d exp=%0d",
                             n, bus.o_grant_id, order[n]);
                end
                n++;
            end
            bus.i_req_valid = bus.i_req_valid & ~exp_ready;
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int k = 0; k < N; k++) set_req(k, AW'(k + 11), 32'h4444_0000 + k);
        bus.i_req_valid = '1;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) i_rst = 1'b0;
            @(negedge i_clk);
            model_cycle();
            checks++;
            if (bus.o_req_ready !== exp_ready) begin
                fails++;
                $display("FAIL mid_ready c=%0d got=%b exp=%b",
                         c, bus.o_req_ready, exp_ready);
            end
            if (c == 4) begin
                checks++;
                if (bus.o_req_ready !== 4'b0001) begin
                    fails++;
                    $display("FAIL mid_restart got=%b exp=0001",
                             bus.o_req_ready);
                end
            end
            @(posedge i_clk);
            #1;
            e   = sb.pop_front();
            got = {bus.o_we, bus.o_waddr, bus.o_wdata, bus.o_grant_id};
            checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL mid_out c=%0d got=%h exp=%h", c, got, e);
            end
            if (c == 1) begin
                #2 i_rst = 1'b1;
                #1;
                got = {bus.o_we, bus.o_waddr, bus.o_wdata, bus.o_grant_id};
                checks++;
                if (got !== '0 || bus.o_req_ready !== '0) begin
                    fails++;
                    $display("FAIL mid_async got=%h rdy=%b exp=0 0",
                             got, bus.o_req_ready);
                end
                model_reset();
            end
        end
        bus.i_req_valid = '0;
    endtask

    initial begin
        bus.i_req_valid = '0;
        bus.i_req_addr  = '0;
        bus.i_req_data  = '0;
        bus.i_stall     = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_reg0_drop();
        test_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Round-robin arbiter that shares the register file's single write port between up to N_REQ requesters (e.g. ALU writeback, load unit, multiply/divide unit, debug port). Each requester presents a valid/ready write request. The arbiter grants one per cycle and drives a registered write-enable/address/data triple straight onto the register file write port. Writes to register 0 are accepted and discarded, so requesters need no special-casing.

## Interface
Parameters:
- N_REQ, default 4: number of requesters (2..8).
- ADDR_W, default 5: register address width.
- DATA_W, default 32: register data width.

Ports:
- i_clk, input, 1: clock. All state updates on the rising edge.
- i_rst, input, 1: reset, asynchronous, active-high.
- i_req_valid, input, N_REQ: per-requester request valid.
- i_req_addr, input, N_REQ*ADDR_W: packed destination addresses. Requester k occupies bits [k*ADDR_W +: ADDR_W].
- i_req_data, input, N_REQ*DATA_W: packed write data. Requester k occupies bits [k*DATA_W +: DATA_W].
- i_stall, input, 1: when high, no grants are issued.
- o_req_ready, output, N_REQ: one-hot grant, combinational. At most one bit is set.
- o_we, output, 1: register file write enable, registered.
- o_waddr, output, ADDR_W: register file write address, registered.
- o_wdata, output, DATA_W: register file write data, registered.
- o_grant_id, output, clog2(N_REQ): index of the requester whose write is currently on o_we/o_waddr/o_wdata, registered.

## Operation
- Handshake: a transfer occurs for requester k in any cycle where i_req_valid[k] and o_req_ready[k] are both 1.
  - Requester k holds valid, address and data stable until that transfer.
  - Valid must not be withdrawn before the transfer.
- Grant selection, evaluated combinationally every cycle:
  - Priority pointer ptr, range 0..N_REQ-1.
  - Search order is ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1, taken modulo N_REQ.
  - The first requester in that order with valid set is granted.
  - No grant is issued when i_stall=1, when i_rst=1, or when no requester is valid.
- Pointer update: after a grant to requester g, ptr becomes (g+1) mod N_REQ on the same clock edge. With no grant, ptr holds.
- Output stage, updated on the edge that completes a transfer from requester g:
  - If the address is nonzero: o_we←1, o_waddr←addr_g, o_wdata←data_g, o_grant_id←g.
  - If the address is 0: o_we←0, while o_waddr, o_wdata and o_grant_id still load. The write is dropped but the handshake is completed.
- With no transfer on an edge: o_we←0, and o_waddr, o_wdata and o_grant_id hold their previous values.
- Fairness: a continuously valid requester is granted within N_REQ unstalled cycles.
- Reset, while i_rst is high:
  - o_we=0, o_waddr=0, o_wdata=0, o_grant_id=0, ptr=0.
  - o_req_ready=0.
- Reset mid-operation: a write already registered on o_we is cancelled asynchronously, and no partial transfer is recorded. A requester waiting for ready keeps waiting and is re-arbitrated after reset deasserts, starting from ptr=0.

## Timing
- Grant latency: o_req_ready is asserted in the same cycle as i_req_valid, provided the requester wins arbitration and is not stalled.
- Write latency: transfer at edge T drives o_we=1 for cycle T..T+1, and the register file captures the write at edge T+1.
- Throughput: one write per cycle, back-to-back, with no bubbles while any requester is valid.
- i_stall is sampled combinationally. The cycle in which it rises produces no grant.
- Combinational paths:
  - i_req_valid and i_stall to o_req_ready: one priority search.
  - No path from the data or address inputs to any output other than through registers.

## Configuration
- REGFILE_ARB_STATS_EN:
  - When defined, the block adds output o_stat_grants (N_REQ*16 bits): per-requester 16-bit saturating grant counters, incremented on every transfer including dropped ones.
  - It also adds output o_stat_drops (16 bits): a saturating count of register-0 writes.
  - All counters reset to 0 and saturate at 0xFFFF.
  - When not defined, these ports and counters are absent, and all other behaviour is identical.

## Test plan
- Reset: assert i_rst with all requesters valid → o_req_ready=0000, o_we=0, o_waddr=0, o_wdata=0. Deassert reset → requester 0 is granted first.
- Single writer: only requester 2 valid with addr=5, data=0xDEADBEEF → o_req_ready=0100 in the same cycle. Next cycle o_we=1, o_waddr=5, o_wdata=0xDEADBEEF, o_grant_id=2.
- Round-robin: all 4 requesters held valid for 8 cycles → grants in order 0,1,2,3,0,1,2,3, with o_we high for 8 consecutive cycles.
- Register-0 drop: requester 1 writes addr=0, data=0x1234 → handshake completes, o_we stays 0, and o_stat_drops=1 when REGFILE_ARB_STATS_EN is defined.
- Stall and fairness: requesters 0 and 3 valid, i_stall=1 for 3 cycles → no grants, ptr unchanged. Release stall → grants 0 then 3.
- Reset mid-stream: assert i_rst asynchronously while o_we=1 → o_we drops to 0 immediately. Deassert reset → arbitration restarts from requester 0.
